// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares the single write port of the FIFO among N_REQ producers. One producer
// owns the port at a time and keeps it for a burst of up to MAX_BURST words.
// Ownership rotates round-robin. Writes stall while the FIFO reports full.
//
// Ports
//   clk        in   1                  clock; all state updates on posedge
//   reset      in   1                  synchronous, active-high
//   req        in   N_REQ              req[i]=1: requester i offers a word
//   wdata      in   N_REQ*DATA_WIDTH   slice i = wdata[i*DATA_WIDTH +: DATA_WIDTH]
//   fifo_full  in   1                  full flag from the FIFO controller
//   grant      out  N_REQ              registered one-hot owner, 0 when idle
//   ack        out  N_REQ              one-hot; word of requester i written now
//   fifo_wr    out  1                  FIFO write strobe
//   fifo_wdata out  DATA_WIDTH         owner's data slice
//   busy       out  1                  1 whenever grant != 0
// -----------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 24,
  parameter int MAX_BURST  = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*DATA_WIDTH-1:0] wdata,
  input  logic                        fifo_full,
  output logic [N_REQ-1:0]            grant,
  output logic [N_REQ-1:0]            ack,
  output logic                        fifo_wr,
  output logic [DATA_WIDTH-1:0]       fifo_wdata,
  output logic                        busy
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BW    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
  localparam logic [BW-1:0]    BURST_END = BW'(MAX_BURST - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state,      state_next;
  logic [N_REQ-1:0] grant_q,    grant_next;
  logic [IDX_W-1:0] owner_idx,  owner_next;   // binary index of the current owner
  logic [IDX_W-1:0] last_owner, last_next;    // round-robin pointer
  logic [BW-1:0]    burst_cnt,  burst_next;   // words written in this burst

  // ---------------------------------------------------------------------------
  // Per-requester data slices, viewed as an array for a clean index mux
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] slice [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign slice[g] = wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin search
  // In IDLE the search starts after last_owner; in GRANT it starts after the
  // current owner, so the owner itself is visited last. Only the result of the
  // GRANT search is used at a release, where that ordering is what we want.
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0] search_base;
  logic [IDX_W-1:0] cand_idx;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid;

  always_comb begin
    // NOTE: every variable written here is assigned a default first, so no path
    // leaves it holding its old value and no latch is inferred.
    search_base = (state == GRANT) ? owner_idx : last_owner;
    cand_idx    = '0;
    win_idx     = '0;
    win_valid   = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_idx = IDX_W'((int'(search_base) + k) % N_REQ);
      if (!win_valid && req[cand_idx]) begin
        win_valid = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path and next-state logic
  // ---------------------------------------------------------------------------
  logic wr_now;
  logic release_now;

  always_comb begin
    state_next  = state;
    grant_next  = grant_q;
    owner_next  = owner_idx;
    last_next   = last_owner;
    burst_next  = burst_cnt;
    wr_now      = 1'b0;
    release_now = 1'b0;
    ack         = '0;

    unique case (state)
      IDLE: begin
        if (win_valid) begin
          grant_next = N_REQ'(1) << win_idx;
          owner_next = win_idx;
          state_next = GRANT;
        end
      end

      GRANT: begin
        // Only the owner's req bit can produce a write; reset suppresses it.
        wr_now = req[owner_idx] & ~fifo_full & ~reset;
        if (wr_now) begin
          ack        = N_REQ'(1) << owner_idx;
          burst_next = burst_cnt + BW'(1);
        end

        // Release when the owner withdraws, or when this write ends the burst.
        // A full FIFO produces no write, so the burst simply holds.
        release_now = ~req[owner_idx] | (wr_now & (burst_cnt == BURST_END));

        if (release_now) begin
          last_next  = owner_idx;
          burst_next = '0;
          if (win_valid) begin
            // Hand over directly, no idle cycle between bursts.
            grant_next = N_REQ'(1) << win_idx;
            owner_next = win_idx;
          end else begin
            grant_next = '0;
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
        grant_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state      <= IDLE;
      grant_q    <= '0;
      owner_idx  <= LAST_IDX;
      last_owner <= LAST_IDX;   // requester 0 wins the first arbitration
      burst_cnt  <= '0;
    end else begin
      state      <= state_next;
      grant_q    <= grant_next;
      owner_idx  <= owner_next;
      last_owner <= last_next;
      burst_cnt  <= burst_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant   = grant_q;
  assign busy    = |grant_q;
  assign fifo_wr = wr_now;

  // In IDLE the data bus shows last_owner's slice; it is a don't-care there.
  assign fifo_wdata = (state == GRANT) ? slice[owner_idx] : slice[last_owner];

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//
// Directed stimulus for fifo_wr_arbiter (N_REQ=4, DATA_WIDTH=24, MAX_BURST=4).
// Each stimulus cycle states the expected grant and write strobe; for each
// expected write the owning requester is queued. A separate monitor pops the
// queue on every observed write and compares ack and fifo_wdata.
// Inputs change 1 ns after posedge; outputs are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N_REQ = 4;
  localparam int DW    = 24;
  localparam int MB    = 4;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic [N_REQ-1:0]      req = '0;
  logic [N_REQ*DW-1:0]   wdata;
  logic                  fifo_full = 1'b0;
  logic [N_REQ-1:0]      grant;
  logic [N_REQ-1:0]      ack;
  logic                  fifo_wr;
  logic [DW-1:0]         fifo_wdata;
  logic                  busy;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int mon_owner;

  // Distinct data per slice: 0xA00000 + i
  assign wdata = {24'hA00003, 24'hA00002, 24'hA00001, 24'hA00000};

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .N_REQ      (N_REQ),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .wdata      (wdata),
    .fifo_full  (fifo_full),
    .grant      (grant),
    .ack        (ack),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One stimulus cycle: apply inputs, queue the expected writer, then check
  // grant / busy / fifo_wr in the middle of the cycle.
  task automatic cyc(input string name, input logic rst, input logic [3:0] r,
                     input logic full, input logic [3:0] exp_grant,
                     input logic exp_wr, input int exp_owner);
    @(posedge clk);
    #1;
    reset     = rst;
    req       = r;
    fifo_full = full;
    if (exp_wr) exp_q.push_back(exp_owner);
    @(negedge clk);
    check({name, "_grant"}, {28'b0, grant}, {28'b0, exp_grant});
    check({name, "_busy"},  {31'b0, busy},  {31'b0, |exp_grant});
    check({name, "_wr"},    {31'b0, fifo_wr}, {31'b0, exp_wr});
  endtask

  task automatic do_reset();
    cyc("rst", 1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 0);
  endtask

  // Scoreboard monitor: every write (or stray ack) consumes one expectation.
  always @(negedge clk) begin
    if (fifo_wr === 1'b1 || (ack !== '0 && ack !== 'x)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, fifo_wr}, 32'd0);
      end else begin
        mon_owner = exp_q.pop_front();
        check("sb_ack",   {28'b0, ack},  32'd1 << mon_owner);
        check("sb_wdata", {8'b0, fifo_wdata}, 32'hA00000 + mon_owner);
        check("sb_wr",    {31'b0, fifo_wr}, 32'd1);
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);

    // 1: sole requester 0, two back-to-back bursts, then withdraw
    cyc("t1_c0", 1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 0);
    for (int k = 0; k < 2 * MB; k++)
      cyc("t1_w", 1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t1_drop", 1'b0, 4'b0000, 1'b0, 4'b0001, 1'b0, 0);
    cyc("t1_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    // 2: all requesting, rotation 0,1,2,3,0 with exactly MB writes each
    do_reset();
    cyc("t2_c0", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 0);
    for (int b = 0; b < 5; b++)
      for (int k = 0; k < MB; k++)
        cyc("t2_w", 1'b0, 4'b1111, 1'b0, 4'(1 << (b % 4)), 1'b1, b % 4);
    cyc("t2_drop", 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 0);
    cyc("t2_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    // 3: owner 0 stalls on full after 2 words, finishes, hands to 1
    do_reset();
    cyc("t3_c0", 1'b0, 4'b0011, 1'b0, 4'b0000, 1'b0, 0);
    cyc("t3_w0", 1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t3_w1", 1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 0);
    for (int k = 0; k < 3; k++)
      cyc("t3_full", 1'b0, 4'b0011, 1'b1, 4'b0001, 1'b0, 0);
    cyc("t3_w2", 1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t3_w3", 1'b0, 4'b0011, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t3_next", 1'b0, 4'b0011, 1'b0, 4'b0010, 1'b1, 1);
    cyc("t3_drop", 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 0);
    cyc("t3_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    // 4: owner 2 withdraws after one word; then search order 3 before 0
    do_reset();
    cyc("t4_c0",   1'b0, 4'b0100, 1'b0, 4'b0000, 1'b0, 0);
    cyc("t4_w2",   1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2);
    cyc("t4_drop", 1'b0, 4'b0010, 1'b0, 4'b0100, 1'b0, 0);
    cyc("t4_w1",   1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, 1);
    cyc("t4_rr",   1'b0, 4'b1001, 1'b0, 4'b0010, 1'b0, 0);
    cyc("t4_w3",   1'b0, 4'b1001, 1'b0, 4'b1000, 1'b1, 3);
    cyc("t4_end",  1'b0, 4'b0000, 1'b0, 4'b1000, 1'b0, 0);
    cyc("t4_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    // 5: reset mid-burst; no write in reset cycle, fresh burst from 0 after
    do_reset();
    cyc("t5_c0",  1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 0);
    cyc("t5_w0",  1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t5_w1",  1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t5_rst", 1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 0);
    cyc("t5_arb", 1'b0, 4'b1111, 1'b0, 4'b0000, 1'b0, 0);
    for (int k = 0; k < MB; k++)
      cyc("t5_w", 1'b0, 4'b1111, 1'b0, 4'b0001, 1'b1, 0);
    cyc("t5_next", 1'b0, 4'b1111, 1'b0, 4'b0010, 1'b1, 1);
    cyc("t5_drop", 1'b0, 4'b0000, 1'b0, 4'b0010, 1'b0, 0);
    cyc("t5_idle", 1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 0);

    @(posedge clk);
    @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
